// File: rtl/max7219_receiver.sv
// max7219_receiver: MAX7219-compatible SPI responder.
// Synchronizes spi_clk/din/cs into clk, shifts 16-bit frames, commits on cs
// rising and renders eight registered digit images from the register file.
// Optional Code-B font decoding is enabled by defining MAX7219_CODEB_EN.
// Handshake: wr_valid is a one-cycle strobe with no ready; wr_addr/wr_data are
// valid in that cycle and hold their value until the next committed frame.
module max7219_receiver #(
  parameter int         SYNC_STAGES      = 2,
  parameter logic [3:0] RESET_INTENSITY  = 4'd0,
  parameter logic [2:0] RESET_SCAN_LIMIT = 3'd0
) (
  input  logic        clk,
  input  logic        reset_sw,
  input  logic        spi_clk,
  input  logic        din,
  input  logic        cs,
  output logic        dout,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_err,
  output logic [7:0]  decode_mode,
  output logic [3:0]  intensity,
  output logic [2:0]  scan_limit,
  output logic        shutdown_n,
  output logic        display_test,
  output logic [63:0] digit_seg,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] spi_sync, din_sync, cs_sync;
  logic spi_prev, cs_prev;
  logic spi_s, din_s, cs_s;
  logic spi_rise, spi_fall, cs_rise, cs_fall;

  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [7:0]  digit_reg [8];
  logic [3:0]  frame_addr;
  logic [7:0]  frame_data;
  logic [2:0]  digit_idx;

  logic start_frame, commit_ok, commit_err, shift_en, dout_en;

  assign spi_s      = spi_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign spi_rise   = spi_s & ~spi_prev;
  assign spi_fall   = ~spi_s & spi_prev;
  assign cs_rise    = cs_s & ~cs_prev;
  assign cs_fall    = ~cs_s & cs_prev;
  assign frame_addr = shift_reg[11:8];
  assign frame_data = shift_reg[7:0];
  assign digit_idx  = frame_addr[2:0] - 3'd1;
  assign dbg_state  = state;

  // Synchronizer chains plus edge-detect history. cs resets low so a frame
  // interrupted by reset is ignored until a fresh cs falling edge.
  always_ff @(posedge clk) begin
    if (reset_sw) begin
      spi_sync <= '0;
      din_sync <= '0;
      cs_sync  <= '0;
      spi_prev <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      spi_sync <= {spi_sync[SYNC_STAGES-2:0], spi_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], din};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      spi_prev <= spi_s;
      cs_prev  <= cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset_sw) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state and per-cycle frame actions.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    commit_ok   = 1'b0;
    commit_err  = 1'b0;
    shift_en    = 1'b0;
    dout_en     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next  = SHIFT;
          start_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = COMMIT;
          if (bit_cnt >= 5'd16) commit_ok  = 1'b1;
          else                  commit_err = 1'b1;
        end else begin
          shift_en = spi_rise & ~cs_s;
          dout_en  = spi_fall & ~cs_s;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift register, bit counter, daisy-chain output and commit strobes.
  always_ff @(posedge clk) begin
    if (reset_sw) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      dout      <= 1'b0;
      wr_valid  <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid  <= commit_ok;
      frame_err <= commit_err;
      if (start_frame) bit_cnt <= '0;
      if (shift_en) begin
        shift_reg <= {shift_reg[14:0], din_s};
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
      end
      if (dout_en) dout <= shift_reg[15];
      if (commit_ok) begin
        wr_addr <= frame_addr;
        wr_data <= frame_data;
      end
    end
  end

  // Register file write on a committed frame; NOP, 0xD and 0xE change nothing.
  always_ff @(posedge clk) begin
    if (reset_sw) begin
      decode_mode  <= '0;
      intensity    <= RESET_INTENSITY;
      scan_limit   <= RESET_SCAN_LIMIT;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      for (int i = 0; i < 8; i++) digit_reg[i] <= '0;
    end else if (commit_ok) begin
      case (frame_addr)
        4'h1, 4'h2, 4'h3, 4'h4,
        4'h5, 4'h6, 4'h7, 4'h8: digit_reg[digit_idx] <= frame_data;
        4'h9:    decode_mode  <= frame_data;
        4'hA:    intensity    <= frame_data[3:0];
        4'hB:    scan_limit   <= frame_data[2:0];
        4'hC:    shutdown_n   <= frame_data[0];
        4'hF:    display_test <= frame_data[0];
        default: ;
      endcase
    end
  end

`ifdef MAX7219_CODEB_EN
  // Code-B font: segments A..G in bits 6..0.
  function automatic logic [6:0] codeb(input logic [3:0] v);
    case (v)
      4'h0: codeb = 7'h7E;  4'h1: codeb = 7'h30;
      4'h2: codeb = 7'h6D;  4'h3: codeb = 7'h79;
      4'h4: codeb = 7'h33;  4'h5: codeb = 7'h5B;
      4'h6: codeb = 7'h5F;  4'h7: codeb = 7'h70;
      4'h8: codeb = 7'h7F;  4'h9: codeb = 7'h7B;
      4'hA: codeb = 7'h01;  4'hB: codeb = 7'h4F;
      4'hC: codeb = 7'h37;  4'hD: codeb = 7'h0E;
      4'hE: codeb = 7'h67;  default: codeb = 7'h00;
    endcase
  endfunction
`endif

  // Per-digit image: test overrides shutdown, which overrides scan limit.
  always_ff @(posedge clk) begin
    if (reset_sw) begin
      digit_seg <= '0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (display_test)           digit_seg[8*n +: 8] <= 8'hFF;
        else if (!shutdown_n)       digit_seg[8*n +: 8] <= 8'h00;
        else if (3'(n) > scan_limit) digit_seg[8*n +: 8] <= 8'h00;
`ifdef MAX7219_CODEB_EN
        else if (decode_mode[n])
          digit_seg[8*n +: 8] <= {digit_reg[n][7], codeb(digit_reg[n][3:0])};
`endif
        else                        digit_seg[8*n +: 8] <= digit_reg[n];
      end
    end
  end

endmodule

// File: tb/tb_max7219_receiver.sv
// tb_max7219_receiver: directed bench for max7219_receiver.
// Honours MAX7219_CODEB_EN to select expected decoded or raw digit images.
`timescale 1ns/1ps
module tb_max7219_receiver;

  localparam int HALF = 6;  // clk cycles per spi_clk half period

  logic        clk = 1'b0;
  logic        reset_sw = 1'b1;
  logic        spi_clk = 1'b0;
  logic        din = 1'b0;
  logic        cs = 1'b1;
  logic        dout, wr_valid, frame_err, shutdown_n, display_test;
  logic [3:0]  wr_addr, intensity;
  logic [7:0]  wr_data, decode_mode;
  logic [2:0]  scan_limit;
  logic [63:0] digit_seg;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  int wr_base, err_base;
  logic [31:0] dout_hist = '0;
  logic [63:0] exp_seg;

  max7219_receiver dut (
    .clk(clk), .reset_sw(reset_sw), .spi_clk(spi_clk), .din(din), .cs(cs),
    .dout(dout), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown_n(shutdown_n),
    .display_test(display_test), .digit_seg(digit_seg), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Strobe counters.
  always @(posedge clk) begin
    if (wr_valid)  wr_cnt  = wr_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Shift n bits MSB first; dout is sampled just before each rising spi_clk.
  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = data[i];
      repeat (HALF) @(negedge clk);
      dout_hist = {dout_hist[30:0], dout};
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] data, input int n);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(data, n);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // 1. Reset state
    repeat (5) @(negedge clk);
    reset_sw = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_dout", 64'(dout), 64'h0);
    check("rst_wr_valid", 64'(wr_valid), 64'h0);
    check("rst_frame_err", 64'(frame_err), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    check("rst_decode", 64'(decode_mode), 64'h0);
    check("rst_intensity", 64'(intensity), 64'h0);
    check("rst_scan", 64'(scan_limit), 64'h0);
    check("rst_shutdown_n", 64'(shutdown_n), 64'h0);
    check("rst_test", 64'(display_test), 64'h0);
    check("rst_digit_seg", digit_seg, 64'h0);

    // 2. First frame with commit latency: 3rd rising edge after cs high
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'h0C01, 16);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_wr_valid_early", 64'(wr_valid), 64'h0);
    check("lat_shutdown_early", 64'(shutdown_n), 64'h0);
    @(negedge clk);
    check("lat_wr_valid", 64'(wr_valid), 64'h1);
    check("lat_shutdown", 64'(shutdown_n), 64'h1);
    check("lat_wr_addr", 64'(wr_addr), 64'hC);
    check("lat_wr_data", 64'(wr_data), 64'h01);
    @(negedge clk);
    check("lat_wr_valid_pulse", 64'(wr_valid), 64'h0);
    repeat (8) @(negedge clk);
    frame(32'h0B07, 16);
    frame(32'h0155, 16);
    check("f2_scan", 64'(scan_limit), 64'h7);
    check("f2_digit_seg", digit_seg, 64'h55);
    check("f2_wr_cnt", 64'(wr_cnt), 64'd3);
    check("f2_err_cnt", 64'(err_cnt), 64'd0);
    check("f2_wr_addr", 64'(wr_addr), 64'h1);
    check("f2_wr_data", 64'(wr_data), 64'h55);

    // 3. Display test overrides shutdown
    frame(32'h0C00, 16);
    check("sd_digit_seg", digit_seg, 64'h0);
    frame(32'h0F01, 16);
    check("test_on", 64'(display_test), 64'h1);
    check("test_digit_seg", digit_seg, 64'hFFFF_FFFF_FFFF_FFFF);
    frame(32'h0F00, 16);
    check("test_off_seg", digit_seg, 64'h0);
    frame(32'h0C01, 16);
    check("wake_digit_seg", digit_seg, 64'h55);

    // 4. Short frame
    wr_base = wr_cnt;
    err_base = err_cnt;
    frame(32'h0A3, 12);
    check("short_err", 64'(err_cnt - err_base), 64'd1);
    check("short_no_wr", 64'(wr_cnt - wr_base), 64'd0);
    check("short_intensity", 64'(intensity), 64'h0);
    check("short_wr_addr", 64'(wr_addr), 64'hC);
    check("short_wr_data", 64'(wr_data), 64'h01);

    // 5. 24-bit frame: last 16 bits commit, first byte appears on dout
    frame(32'hAB0A05, 24);
    check("long_intensity", 64'(intensity), 64'h5);
    check("long_wr_addr", 64'(wr_addr), 64'hA);
    check("long_wr_data", 64'(wr_data), 64'h05);
    check("long_dout", 64'(dout_hist[7:0]), 64'hAB);

    // 6. Decode mode on digits 0 and 1
    frame(32'h09FF, 16);
    frame(32'h0283, 16);
    check("dec_mode", 64'(decode_mode), 64'hFF);
`ifdef MAX7219_CODEB_EN
    exp_seg = 64'h7E7E_7E7E_7E7E_F95B;
`else
    exp_seg = 64'h0000_0000_0000_8355;
`endif
    check("dec_digit1", 64'(digit_seg[15:8]), 64'(exp_seg[15:8]));
    check("dec_digit_seg", digit_seg, exp_seg);

    // Scan limit boundary: only digits 0..1 shown
    frame(32'h0B01, 16);
`ifdef MAX7219_CODEB_EN
    exp_seg = 64'h0000_0000_0000_F95B;
`else
    exp_seg = 64'h0000_0000_0000_8355;
`endif
    check("scan1_digit_seg", digit_seg, exp_seg);

    // Reset mid-frame: remainder ignored
    wr_base = wr_cnt;
    err_base = err_cnt;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    send_bits(32'h0C, 8);
    reset_sw = 1'b1;
    repeat (3) @(negedge clk);
    reset_sw = 1'b0;
    send_bits(32'h01, 8);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_wr", 64'(wr_cnt - wr_base), 64'd0);
    check("mid_rst_no_err", 64'(err_cnt - err_base), 64'd0);
    check("mid_rst_shutdown", 64'(shutdown_n), 64'h0);
    check("mid_rst_scan", 64'(scan_limit), 64'h0);
    check("mid_rst_decode", 64'(decode_mode), 64'h0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'h0);
    check("mid_rst_digit_seg", digit_seg, 64'h0);

    // Normal operation resumes after reset
    frame(32'h0A0F, 16);
    check("post_rst_intensity", 64'(intensity), 64'hF);
    check("post_rst_wr_cnt", 64'(wr_cnt - wr_base), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
